// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the threshold FIFO.
package fifo_pkg;

  localparam int unsigned FIFO_DEF_WORD_LEN = 8;
  localparam int unsigned FIFO_DEF_SIZE     = 8;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned v = (value > 0) ? value - 1 : 0; v > 0; v = v >> 1) begin
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_thresh_if.sv
// en/rdy handshake bundle between producer, FIFO and consumer.
interface fifo_thresh_if #(
  parameter int unsigned p_WORD_LEN = fifo_pkg::FIFO_DEF_WORD_LEN
);

  logic [p_WORD_LEN-1:0] enq_data;
  logic                  enq_en;
  logic                  enq_rdy;
  logic [p_WORD_LEN-1:0] deq_data;
  logic                  deq_en;
  logic                  deq_rdy;

  modport master (
    output enq_data, enq_en, deq_en,
    input  enq_rdy, deq_data, deq_rdy
  );

  modport slave (
    input  enq_data, enq_en, deq_en,
    output enq_rdy, deq_data, deq_rdy
  );

endinterface

// File: rtl/fifo_thresh_mem.sv
// Simple dual-port register array: one synchronous write port, one registered read port.
module fifo_thresh_mem import fifo_pkg::*; #(
  parameter int unsigned p_WORD_LEN  = FIFO_DEF_WORD_LEN,
  parameter int unsigned p_FIFO_SIZE = FIFO_DEF_SIZE
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           wr_en_i,
  input  logic [clog2(p_FIFO_SIZE)-1:0]  wr_addr_i,
  input  logic [p_WORD_LEN-1:0]          wr_data_i,
  input  logic                           rd_en_i,
  input  logic [clog2(p_FIFO_SIZE)-1:0]  rd_addr_i,
  input  logic                           rd_clr_i,
  output logic [p_WORD_LEN-1:0]          rd_data_o
);

  logic [p_WORD_LEN-1:0] mem_q [p_FIFO_SIZE];
  logic [p_WORD_LEN-1:0] rd_data_q;

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_clr_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_thresh.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and flush.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAG_EN is defined.
module fifo_thresh import fifo_pkg::*; #(
  parameter int unsigned p_WORD_LEN      = FIFO_DEF_WORD_LEN,
  parameter int unsigned p_FIFO_SIZE     = FIFO_DEF_SIZE,
  parameter int unsigned p_AFULL_THRESH  = p_FIFO_SIZE - 2,
  parameter int unsigned p_AEMPTY_THRESH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  fifo_thresh_if.slave                 bus,
  output logic                         o_full,
  output logic                         o_empty,
  output logic                         o_afull,
  output logic                         o_aempty,
  output logic [clog2(p_FIFO_SIZE):0]  o_count,
  output logic                         o_overflow,
  output logic                         o_underflow
);

  localparam int unsigned PtrW = clog2(p_FIFO_SIZE);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  full, empty;
  logic                  enq_acc, deq_acc;
  logic [p_WORD_LEN-1:0] deq_data;

  // Status comes only from registered state, so rdy never depends on en.
  assign full    = (count_q == CntW'(p_FIFO_SIZE));
  assign empty   = (count_q == '0);
  assign enq_acc = bus.enq_en & ~full;
  assign deq_acc = bus.deq_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_acc) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (deq_acc) rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (enq_acc && !deq_acc) begin
        count_d = count_q + CntW'(1);
      end else if (!enq_acc && deq_acc) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_thresh_mem #(
    .p_WORD_LEN  (p_WORD_LEN),
    .p_FIFO_SIZE (p_FIFO_SIZE)
  ) u_mem (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .wr_en_i   (enq_acc & ~i_flush),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (bus.enq_data),
    .rd_en_i   (deq_acc & ~i_flush),
    .rd_addr_i (rd_ptr_q),
    .rd_clr_i  (i_flush),
    .rd_data_o (deq_data)
  );

  assign bus.deq_data = deq_data;
  assign bus.enq_rdy  = ~full;
  assign bus.deq_rdy  = ~empty;
  assign o_full       = full;
  assign o_empty      = empty;
  assign o_afull      = (count_q >= CntW'(p_AFULL_THRESH));
  assign o_aempty     = (count_q <= CntW'(p_AEMPTY_THRESH));
  assign o_count      = count_q;

`ifdef FIFO_ERR_FLAG_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (i_flush) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.enq_en && full)  overflow_q  <= 1'b1;
      if (bus.deq_en && empty) underflow_q <= 1'b1;
    end
  end

  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;
`else
  assign o_overflow  = 1'b0;
  assign o_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_thresh.sv
// Directed self-checking bench for fifo_thresh (8 x 8, afull at 6, aempty at 2).
module tb_fifo_thresh;

`ifdef FIFO_ERR_FLAG_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       flush;
  logic       full, empty, afull, aempty, overflow, underflow;
  logic [3:0] count;

  int n_tests;
  int n_fail;

  fifo_thresh_if #(.p_WORD_LEN(8)) bus ();

  fifo_thresh #(
    .p_WORD_LEN      (8),
    .p_FIFO_SIZE     (8),
    .p_AFULL_THRESH  (6),
    .p_AEMPTY_THRESH (2)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (flush),
    .bus         (bus),
    .o_full      (full),
    .o_empty     (empty),
    .o_afull     (afull),
    .o_aempty    (aempty),
    .o_count     (count),
    .o_overflow  (overflow),
    .o_underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected flags for a given occupancy with thresholds 6 and 2.
  task automatic check_status(input string tag, input int cnt);
    check_eq({tag, ".count"},   32'(count),       32'(cnt));
    check_eq({tag, ".empty"},   32'(empty),       32'(cnt == 0));
    check_eq({tag, ".full"},    32'(full),        32'(cnt == 8));
    check_eq({tag, ".afull"},   32'(afull),       32'(cnt >= 6));
    check_eq({tag, ".aempty"},  32'(aempty),      32'(cnt <= 2));
    check_eq({tag, ".enq_rdy"}, 32'(bus.enq_rdy), 32'(cnt != 8));
    check_eq({tag, ".deq_rdy"}, 32'(bus.deq_rdy), 32'(cnt != 0));
  endtask

  task automatic check_reset(input string tag);
    check_status(tag, 0);
    check_eq({tag, ".deq_data"},  32'(bus.deq_data), 32'h0);
    check_eq({tag, ".overflow"},  32'(overflow),     32'h0);
    check_eq({tag, ".underflow"}, 32'(underflow),    32'h0);
  endtask

  task automatic enq(input logic [7:0] d);
    bus.enq_en   = 1'b1;
    bus.enq_data = d;
    step();
    bus.enq_en   = 1'b0;
  endtask

  task automatic deq_check(input string tag, input logic [7:0] exp);
    bus.deq_en = 1'b1;
    step();
    bus.deq_en = 1'b0;
    check_eq(tag, 32'(bus.deq_data), 32'(exp));
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b1;
    flush        = 1'b0;
    bus.enq_en   = 1'b0;
    bus.deq_en   = 1'b0;
    bus.enq_data = 8'h00;
    #3;
    check_reset("reset");
    step();
    rst = 1'b0;
    step();

    // Fill
    for (int i = 0; i < 8; i++) begin
      enq(8'(8'h10 + i));
      check_status($sformatf("fill%0d", i), i + 1);
    end

    // Drain in order, one cycle after each deq_en
    for (int i = 0; i < 8; i++) begin
      deq_check($sformatf("drain%0d.data", i), 8'(8'h10 + i));
      check_status($sformatf("drain%0d", i), 7 - i);
    end

    // Wrap with concurrent traffic at steady occupancy 3
    for (int i = 0; i < 3; i++) enq(8'(8'h20 + i));
    for (int i = 0; i < 20; i++) begin
      bus.enq_en   = 1'b1;
      bus.enq_data = 8'(8'h23 + i);
      bus.deq_en   = 1'b1;
      step();
      check_eq($sformatf("wrap%0d.data", i), 32'(bus.deq_data), 32'(8'h20 + i));
      check_eq($sformatf("wrap%0d.count", i), 32'(count), 32'd3);
    end
    bus.enq_en = 1'b0;
    bus.deq_en = 1'b0;
    for (int i = 0; i < 3; i++) deq_check($sformatf("wrapdrain%0d", i), 8'(8'h34 + i));
    check_status("wrapend", 0);

    // Full: enq+deq, enqueue rejected
    for (int i = 0; i < 8; i++) enq(8'(8'h40 + i));
    check_status("full", 8);
    bus.enq_en   = 1'b1;
    bus.enq_data = 8'hAA;
    bus.deq_en   = 1'b1;
    step();
    bus.enq_en = 1'b0;
    bus.deq_en = 1'b0;
    check_status("fullboth", 7);
    check_eq("fullboth.data", 32'(bus.deq_data), 32'h40);
    check_eq("ovf.set", 32'(overflow), 32'(ErrEn));
    step();
    check_eq("ovf.sticky", 32'(overflow), 32'(ErrEn));
    for (int i = 1; i < 8; i++) deq_check($sformatf("postfull%0d", i), 8'(8'h40 + i));
    check_status("postfull", 0);

    // Empty: enq+deq, dequeue rejected
    bus.enq_en   = 1'b1;
    bus.enq_data = 8'h55;
    bus.deq_en   = 1'b1;
    step();
    bus.enq_en = 1'b0;
    bus.deq_en = 1'b0;
    check_status("emptyboth", 1);
    check_eq("emptyboth.data", 32'(bus.deq_data), 32'h47);
    check_eq("unf.set", 32'(underflow), 32'(ErrEn));
    check_eq("ovf.still", 32'(overflow), 32'(ErrEn));

    // Flush clears everything
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_reset("flush");

    // Async reset mid-stream with 5 words held
    for (int i = 0; i < 6; i++) enq(8'(8'h60 + i));
    deq_check("pre_rst.data", 8'h60);
    check_status("pre_rst", 5);
    #2;
    rst = 1'b1;
    #2;
    check_reset("async_rst");
    rst = 1'b0;
    step();
    check_reset("post_rst");
    enq(8'h77);
    deq_check("post_rst.order", 8'h77);

    // Flush with a concurrent enqueue discards the word
    for (int i = 0; i < 5; i++) enq(8'(8'h80 + i));
    flush        = 1'b1;
    bus.enq_en   = 1'b1;
    bus.enq_data = 8'h99;
    step();
    flush      = 1'b0;
    bus.enq_en = 1'b0;
    check_reset("flush_enq");
    step();
    check_status("flush_enq.hold", 0);
    enq(8'h5A);
    deq_check("post_flush.order", 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
